// File: rtl/sal_sched_pkg.sv
// ---------------------------------------------------------------------------
// sal_sched_pkg
//   Shared types and constants for the DRAM command scheduler.
//   - sched_cmd_e  : encoding of the command driven on the PHY command bus
//   - CLS_*        : command class indices (one round-robin arbiter per class)
//   - PRIO_*       : class search order, normal and column-aged
//   - FAW_SLOTS    : number of activates tracked by the four-activate window
//   - cls_to_cmd   : maps a class index to its bus command code
// ---------------------------------------------------------------------------
package sal_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } sched_cmd_e;

    localparam int CLS_N   = 5;
    localparam int CLS_ACT = 0;
    localparam int CLS_RD  = 1;
    localparam int CLS_WR  = 2;
    localparam int CLS_PRE = 3;
    localparam int CLS_REF = 4;

    // Position 0 is searched first.
    localparam int PRIO_NORMAL [CLS_N] = '{CLS_ACT, CLS_RD, CLS_WR, CLS_PRE, CLS_REF};
    localparam int PRIO_AGED   [CLS_N] = '{CLS_RD, CLS_WR, CLS_ACT, CLS_PRE, CLS_REF};

    localparam int FAW_SLOTS = 4;

    function automatic sched_cmd_e cls_to_cmd(input int cls);
        case (cls)
            CLS_ACT: return CMD_ACT;
            CLS_RD:  return CMD_RD;
            CLS_WR:  return CMD_WR;
            CLS_PRE: return CMD_PRE;
            CLS_REF: return CMD_REF;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// ---------------------------------------------------------------------------
// sal_rr_arb
//   Combinational round-robin picker: grants the first requesting bank at an
//   index >= ptr_i, wrapping past BK_CNT-1 back to 0.
//   Ports:
//     req_i  [BK_CNT] : per-bank request vector
//     ptr_i  [BA_W]   : bank index to start searching from
//     gnt_o  [BK_CNT] : one-hot grant (all zero when no request)
//     idx_o  [BA_W]   : index of the granted bank (0 when no request)
//     any_o           : at least one request present
// ---------------------------------------------------------------------------
module sal_rr_arb #(
    parameter int BK_CNT = 16,
    parameter int BA_W   = 4
) (
    input  logic [BK_CNT-1:0] req_i,
    input  logic [BA_W-1:0]   ptr_i,
    output logic [BK_CNT-1:0] gnt_o,
    output logic [BA_W-1:0]   idx_o,
    output logic              any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < BK_CNT; i++) begin
            j = (int'(ptr_i) + i) % BK_CNT;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = BA_W'(j);
            end
        end
    end

endmodule

// File: rtl/sal_sched_rr.sv
// ---------------------------------------------------------------------------
// sal_sched_rr
//   Single-bus DRAM command scheduler. Each cycle it picks at most one
//   ACT/RD/WR/PRE/REF among BK_CNT bank controllers, combinationally from the
//   current requests and its registered timing state.
//   Ports:
//     clk, rst                    : clock, asynchronous active-high reset
//     {act,rd,wr,pre,ref}_req     : per-bank requests
//     ra/ca/id/len_arr            : per-bank fields, bank i at [i*W +: W]
//     t_{rrd,ccd,rtw,wtr,faw}_m1  : timing minus one, captured when loaded
//     starve_limit                : column aging threshold, 0 disables aging
//     {act,rd,wr,pre,ref}_gnt     : one-hot grants (at most one bit overall)
//     cmd_valid/cmd_type          : issued command, NOP with zero fields if none
//     cmd_ba/ra/ca/id/len         : command fields (ra only for ACT,
//                                   ca/id/len only for RD/WR)
// ---------------------------------------------------------------------------
module sal_sched_rr
    import sal_sched_pkg::*;
#(
    parameter int BK_CNT   = 16,
    parameter int BA_W     = 4,
    parameter int RA_W     = 16,
    parameter int CA_W     = 10,
    parameter int ID_W     = 4,
    parameter int LEN_W    = 4,
    parameter int TCNT_W   = 6,
    parameter int STARVE_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BK_CNT-1:0]       act_req,
    input  logic [BK_CNT-1:0]       rd_req,
    input  logic [BK_CNT-1:0]       wr_req,
    input  logic [BK_CNT-1:0]       pre_req,
    input  logic [BK_CNT-1:0]       ref_req,
    input  logic [BK_CNT*RA_W-1:0]  ra_arr,
    input  logic [BK_CNT*CA_W-1:0]  ca_arr,
    input  logic [BK_CNT*ID_W-1:0]  id_arr,
    input  logic [BK_CNT*LEN_W-1:0] len_arr,
    input  logic [TCNT_W-1:0]       t_rrd_m1,
    input  logic [TCNT_W-1:0]       t_ccd_m1,
    input  logic [TCNT_W-1:0]       t_rtw_m1,
    input  logic [TCNT_W-1:0]       t_wtr_m1,
    input  logic [TCNT_W-1:0]       t_faw_m1,
    input  logic [STARVE_W-1:0]     starve_limit,
    output logic [BK_CNT-1:0]       act_gnt,
    output logic [BK_CNT-1:0]       rd_gnt,
    output logic [BK_CNT-1:0]       wr_gnt,
    output logic [BK_CNT-1:0]       pre_gnt,
    output logic [BK_CNT-1:0]       ref_gnt,
    output logic                    cmd_valid,
    output logic [2:0]              cmd_type,
    output logic [BA_W-1:0]         cmd_ba,
    output logic [RA_W-1:0]         cmd_ra,
    output logic [CA_W-1:0]         cmd_ca,
    output logic [ID_W-1:0]         cmd_id,
    output logic [LEN_W-1:0]        cmd_len
);

    localparam logic [BA_W-1:0] LAST_BK = BA_W'(BK_CNT - 1);

    // Per-class request/arbitration signals.
    logic [BK_CNT-1:0]          cls_req [CLS_N];
    logic [BK_CNT-1:0]          cls_gnt [CLS_N];
    logic [BA_W-1:0]            cls_idx [CLS_N];
    logic                       cls_any [CLS_N];
    logic [CLS_N-1:0]           cls_ok;
    logic [CLS_N-1:0][BA_W-1:0] ptr_q, ptr_d;

    logic [CLS_N-1:0] win_oh;
    logic [BA_W-1:0]  win_idx;
    sched_cmd_e       win_cmd;
    logic             rw_sel, rw_req, aged;

    logic [TCNT_W-1:0] rrd_q, rrd_d, ccd_q, ccd_d, rtw_q, rtw_d, wtr_q, wtr_d;
    logic [TCNT_W-1:0] faw_q [FAW_SLOTS];
    logic [TCNT_W-1:0] faw_d [FAW_SLOTS];
    logic [FAW_SLOTS-1:0] faw_zero, faw_load;
    logic              faw_ok;
    logic [STARVE_W-1:0] col_q, col_d;

    // Counter step: load on grant, otherwise count down and park at zero.
    function automatic logic [TCNT_W-1:0] tick(input logic [TCNT_W-1:0] cur,
                                               input logic              ld,
                                               input logic [TCNT_W-1:0] val);
        if (ld)
            return val;
        if (cur == '0)
            return cur;
        return cur - 1'b1;
    endfunction

    assign cls_req[CLS_ACT] = act_req;
    assign cls_req[CLS_RD]  = rd_req;
    assign cls_req[CLS_WR]  = wr_req;
    assign cls_req[CLS_PRE] = pre_req;
    assign cls_req[CLS_REF] = ref_req;

    for (genvar c = 0; c < CLS_N; c++) begin : g_arb
        sal_rr_arb #(
            .BK_CNT (BK_CNT),
            .BA_W   (BA_W)
        ) u_arb (
            .req_i (cls_req[c]),
            .ptr_i (ptr_q[c]),
            .gnt_o (cls_gnt[c]),
            .idx_o (cls_idx[c]),
            .any_o (cls_any[c])
        );
    end

    // Timing eligibility per class.
    assign cls_ok[CLS_ACT] = (rrd_q == '0) && faw_ok;
    assign cls_ok[CLS_RD]  = (ccd_q == '0) && (wtr_q == '0);
    assign cls_ok[CLS_WR]  = (ccd_q == '0) && (rtw_q == '0);
    assign cls_ok[CLS_PRE] = 1'b1;
    assign cls_ok[CLS_REF] = (rrd_q == '0);

    assign aged = (starve_limit != '0) && (col_q >= starve_limit);

    // Class selection: walk the active priority order, first eligible class
    // with a request wins.
    always_comb begin
        int c;
        win_oh = '0;
        c      = 0;
        for (int p = 0; p < CLS_N; p++) begin
            c = aged ? PRIO_AGED[p] : PRIO_NORMAL[p];
            if ((win_oh == '0) && cls_ok[c] && cls_any[c])
                win_oh[c] = 1'b1;
        end
    end

    always_comb begin
        win_idx = '0;
        win_cmd = CMD_NOP;
        for (int c = 0; c < CLS_N; c++) begin
            if (win_oh[c]) begin
                win_idx = cls_idx[c];
                win_cmd = cls_to_cmd(c);
            end
        end
    end

    assign act_gnt = win_oh[CLS_ACT] ? cls_gnt[CLS_ACT] : '0;
    assign rd_gnt  = win_oh[CLS_RD]  ? cls_gnt[CLS_RD]  : '0;
    assign wr_gnt  = win_oh[CLS_WR]  ? cls_gnt[CLS_WR]  : '0;
    assign pre_gnt = win_oh[CLS_PRE] ? cls_gnt[CLS_PRE] : '0;
    assign ref_gnt = win_oh[CLS_REF] ? cls_gnt[CLS_REF] : '0;

    assign rw_sel  = win_oh[CLS_RD] | win_oh[CLS_WR];
    assign rw_req  = (|rd_req) | (|wr_req);

    assign cmd_valid = |win_oh;
    assign cmd_type  = win_cmd;
    assign cmd_ba    = win_idx;
    assign cmd_ra    = win_oh[CLS_ACT] ? ra_arr[int'(win_idx)*RA_W +: RA_W] : '0;
    assign cmd_ca    = rw_sel ? ca_arr[int'(win_idx)*CA_W +: CA_W]   : '0;
    assign cmd_id    = rw_sel ? id_arr[int'(win_idx)*ID_W +: ID_W]   : '0;
    assign cmd_len   = rw_sel ? len_arr[int'(win_idx)*LEN_W +: LEN_W] : '0;

    // Only the granted class advances its pointer, to one past the winner.
    always_comb begin
        ptr_d = ptr_q;
        for (int c = 0; c < CLS_N; c++) begin
            if (win_oh[c])
                ptr_d[c] = (cls_idx[c] == LAST_BK) ? '0 : cls_idx[c] + 1'b1;
        end
    end

    assign rrd_d = tick(rrd_q, win_oh[CLS_ACT], t_rrd_m1);
    assign ccd_d = tick(ccd_q, rw_sel,          t_ccd_m1);
    assign rtw_d = tick(rtw_q, win_oh[CLS_RD],  t_rtw_m1);
    assign wtr_d = tick(wtr_q, win_oh[CLS_WR],  t_wtr_m1);

    // Column aging counter, saturating at all-ones.
    assign col_d = (!rw_req || rw_sel) ? '0 :
                   (&col_q)            ? col_q : col_q + 1'b1;

    // An ACT claims the lowest free window slot.
    always_comb begin
        faw_load = '0;
        for (int s = 0; s < FAW_SLOTS; s++) begin
            if (win_oh[CLS_ACT] && faw_zero[s] && (faw_load == '0))
                faw_load[s] = 1'b1;
        end
    end

    assign faw_ok = |faw_zero;

    for (genvar s = 0; s < FAW_SLOTS; s++) begin : g_faw
        assign faw_zero[s] = (faw_q[s] == '0);
        // A freshly loaded slot holds its value for the load cycle.
        assign faw_d[s] = faw_load[s] ? t_faw_m1 :
                          faw_zero[s] ? faw_q[s] : faw_q[s] - 1'b1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                faw_q[s] <= '0;
            else
                faw_q[s] <= faw_d[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            rrd_q <= '0;
            ccd_q <= '0;
            rtw_q <= '0;
            wtr_q <= '0;
            col_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rrd_q <= rrd_d;
            ccd_q <= ccd_d;
            rtw_q <= rtw_d;
            wtr_q <= wtr_d;
            col_q <= col_d;
        end
    end

endmodule
